// File: rtl/arbiter_wrr_if.sv
// Request/grant bundle for the weighted round-robin arbiter.
// The lock vector is present only when ARBITER_WRR_LOCK_EN is defined.
interface arbiter_wrr_if #(
  parameter int NUM_PORTS    = 9,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int ID_WIDTH = $clog2(NUM_PORTS);

  logic [0:NUM_PORTS-1]              request;
  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight;
`ifdef ARBITER_WRR_LOCK_EN
  logic [0:NUM_PORTS-1]              lock;
`endif
  logic [0:NUM_PORTS-1]              grant;
  logic [ID_WIDTH-1:0]               grant_id;
  logic                              active;

`ifdef ARBITER_WRR_LOCK_EN
  modport master (output request, weight, lock, input grant, grant_id, active);
  modport slave  (input request, weight, lock, output grant, grant_id, active);
`else
  modport master (output request, weight, input grant, grant_id, active);
  modport slave  (input request, weight, output grant, grant_id, active);
`endif
endinterface

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: each owner keeps the grant for up to its weight
// in consecutive cycles. Optional no-preempt lock via macro ARBITER_WRR_LOCK_EN.
//
// state    | meaning
// ST_IDLE  | no grant outstanding, next request found by search order wins
// ST_OWNED | port `last` holds the grant, `quota` counts remaining extra cycles
module arbiter_wrr #(
  parameter int NUM_PORTS    = 9,
  parameter int WEIGHT_WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  arbiter_wrr_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_PORTS);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t                  state, state_nxt;
  logic [ID_WIDTH-1:0]     last, last_nxt;
  logic [ID_WIDTH-1:0]     gid, gid_nxt;
  logic [WEIGHT_WIDTH-1:0] quota, quota_nxt;
  logic [0:NUM_PORTS-1]    grant_q, grant_nxt;

  logic [WEIGHT_WIDTH-1:0] wt [NUM_PORTS];
  logic                    found_any, found_other;
  logic [ID_WIDTH-1:0]     win_any, win_other;
  logic                    take;
  logic [ID_WIDTH-1:0]     take_id;
  logic                    lock_hold;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wt
    assign wt[i] = bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

`ifdef ARBITER_WRR_LOCK_EN
  assign lock_hold = bus.lock[last];
`else
  assign lock_hold = 1'b0;
`endif

  // Burst of w cycles means w-1 extra cycles after the grant; weight 0 acts as 1.
  function automatic logic [WEIGHT_WIDTH-1:0] load_of(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? '0 : w - 1'b1;
  endfunction

  // Search last+1 .. last+N (mod N); "other" stops before wrapping back to last.
  always_comb begin
    int                  idx;
    logic [ID_WIDTH-1:0] idx_v;
    idx         = 0;
    idx_v       = '0;
    found_any   = 1'b0;
    found_other = 1'b0;
    win_any     = '0;
    win_other   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx   = (int'(last) + k) % NUM_PORTS;
      idx_v = ID_WIDTH'(idx);
      if (!found_any && bus.request[idx_v]) begin
        found_any = 1'b1;
        win_any   = idx_v;
      end
      if (k < NUM_PORTS && !found_other && bus.request[idx_v]) begin
        found_other = 1'b1;
        win_other   = idx_v;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gid_nxt   = gid;
    quota_nxt = quota;
    grant_nxt = grant_q;
    take      = 1'b0;
    take_id   = last;
    case (state)
      ST_IDLE: begin
        if (found_any) begin
          take    = 1'b1;
          take_id = win_any;
        end
      end
      ST_OWNED: begin
        if (!bus.request[last]) begin
          if (found_any) begin
            take    = 1'b1;
            take_id = win_any;
          end else begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
          end
        end else if (quota != '0) begin
          quota_nxt = quota - 1'b1;
        end else if (lock_hold) begin
          quota_nxt = '0;
        end else if (found_other) begin
          take    = 1'b1;
          take_id = win_other;
        end else begin
          quota_nxt = load_of(wt[last]);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
    if (take) begin
      state_nxt          = ST_OWNED;
      last_nxt           = take_id;
      gid_nxt            = take_id;
      quota_nxt          = load_of(wt[take_id]);
      grant_nxt          = '0;
      grant_nxt[take_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      last    <= ID_WIDTH'(NUM_PORTS - 1);
      gid     <= '0;
      quota   <= '0;
      grant_q <= '0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      gid     <= gid_nxt;
      quota   <= quota_nxt;
      grant_q <= grant_nxt;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = gid;
  assign bus.active   = (state == ST_OWNED);
endmodule

// File: doc/arbiter_wrr.md
# arbiter_wrr

Weighted round-robin arbiter: `NUM_PORTS` requesters share one resource, and each port may hold the grant for up to its programmed weight in consecutive cycles before yielding. This is the parametrised successor of the plain round-robin arbiter. It adds per-port burst quotas, a binary grant index and an optional lock. It sits in front of shared buses, memory ports and output FIFOs, wherever unequal bandwidth shares are needed.

## Interface
- `NUM_PORTS`, 9, number of requesters (≥2).
- `WEIGHT_WIDTH`, 4, bits per port weight; max burst is 2^WEIGHT_WIDTH−1 cycles.
- `ID_WIDTH`, derived localparam = `$clog2(NUM_PORTS)`, width of `grant_id`.

Ports:
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `request`  input  [0:NUM_PORTS-1]  per-port request; bit 0 is port 0.
- `weight`  input  [NUM_PORTS*WEIGHT_WIDTH-1:0]  per-port weight, port i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; quasi-static.
- `lock`  input  [0:NUM_PORTS-1]  per-port no-preempt request (only with `ARBITER_WRR_LOCK_EN`).
- `grant`  output  [0:NUM_PORTS-1]  registered one-hot grant, or all zeros.
- `grant_id`  output  ID_WIDTH  index of the granted port; holds its last value when idle.
- `active`  output  1  registered, equals |grant.

## Operation
- State: owner pointer `last` (ID_WIDTH), quota counter `quota` (WEIGHT_WIDTH), registered `grant`.
- Search order: ports `last+1`, `last+2`, … wrapping modulo NUM_PORTS, with `last` itself checked last. The first port with a request set wins.
- IDLE (grant==0):
  - If any request is set, grant the winner.
  - On grant, load `quota` = weight[winner]−1; a weight of 0 is treated as 1.
- OWNED (grant[p]==1):
  - request[p]==0: release. Next cycle, grant the next requester by search order, or go idle. There is no bubble cycle on handoff.
  - request[p]==1 and quota>0: keep the grant and decrement quota.
  - request[p]==1 and quota==0: quota expired. If any other port requests, rotate to it with a fresh quota load. Otherwise keep p and reload quota from weight[p].
- `last` updates to the winner index on every new grant. `grant_id` = `last`.
- A port's weight is sampled only at grant or reload time. Changes mid-burst take effect at the next load.
- Exactly one grant bit is ever high. A grant is never given to a port whose request was low at the deciding edge.

## Timing
- Latency: request sampled high at edge N gives grant high after edge N, visible in cycle N+1 (one cycle).
- Release: request low at edge N clears grant after edge N. The next owner's grant appears in the same cycle.
- Burst length: a continuously requesting port with weight w holds the grant for exactly w cycles when contended.
- Reset (`rst` high at an edge): grant=0, active=0, grant_id=0, quota=0, `last`=NUM_PORTS−1, so port 0 wins first after reset.
  - Reset asserted mid-burst clears the grant on that edge.
  - Requests are ignored while `rst` is high.
- Wrap-around: with owner NUM_PORTS−1, the next search starts at port 0.

## Configuration
- Macro `ARBITER_WRR_LOCK_EN`.
- Defined:
  - The `lock` port exists.
  - While the owner p has request[p] and lock[p] high, quota expiry does not rotate. Quota saturates at 0 and the grant is held.
  - When lock[p] drops with quota==0, rotation occurs at the next edge.
  - Release on request drop is unaffected.
- Undefined: no `lock` port; behaviour is exactly as described under Operation.

## Test plan
All scenarios use NUM_PORTS=9, WEIGHT_WIDTH=4, weights all 1 unless stated.
- Reset: hold rst 10 cycles with request=9'b111111111 → grant=0, active=0 throughout. After release, first grant=9'b100000000, grant_id=0.
- Single requester: request=9'b000000010 held for 15 cycles → grant=9'b000000010 from the next cycle, continuous, quota reloaded. Drop request → grant=0 and active=0 one cycle later.
- Weighted share: weight[0]=3, weight[8]=1, request=9'b100000001 held for 16 cycles → repeating pattern port0×3, port8×1. grant_id sequence is 0,0,0,8,…
- All request, rotate: request=9'b111111111 → grants cycle ports 0→8 one cycle each, then wrap to 0. Clearing port 3's request for one cycle skips it that round.
- Early release: owner port 1 with weight 5 drops request after 2 cycles while port 6 requests → port 6 is granted in the very next cycle, with no idle gap.
- Lock (macro defined): weight[2]=2, lock[2]=1, requests on ports 2 and 4 → port 2 is held beyond 2 cycles. Dropping lock[2] hands the grant to port 4 at the next edge.
